// File: rtl/rd_ctrl_pkg.sv
// Shared types and helpers for the multi-channel read-command generator.
package rd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StReq,
    StDone
  } state_e;

  // AXI beats per command for a given byte length and data width.
  function automatic int unsigned burst_len(input int unsigned wr_length,
                                            input int unsigned data_width);
    return wr_length / (data_width / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last grant, wrapping.
module rr_arbiter #(
  parameter int unsigned P_CH_NUM = 4,
  parameter int unsigned P_CH_W   = $clog2(P_CH_NUM)
) (
  input  logic [P_CH_NUM-1:0] i_req,
  input  logic [P_CH_W-1:0]   i_last_grant,
  output logic [P_CH_W-1:0]   o_grant,
  output logic                o_valid
);

  // Scan from last_grant+1 around to last_grant itself; lowest distance wins.
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    o_grant = '0;
    o_valid = 1'b0;
    for (int unsigned i = 1; i <= P_CH_NUM; i++) begin
      v_idx = (32'(i_last_grant) + i) % P_CH_NUM;
      if (!o_valid && i_req[P_CH_W'(v_idx)]) begin
        o_valid = 1'b1;
        o_grant = P_CH_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/rd_ctrl_mc.sv
// Multi-channel read-command generator: latches per-channel requests, arbitrates
// round-robin, and issues fixed-size bursts walking each channel's circular region.
module rd_ctrl_mc
  import rd_ctrl_pkg::*;
#(
  parameter int unsigned P_CH_NUM         = 4,
  parameter int unsigned P_WR_LENGTH      = 4096,
  parameter int unsigned P_AXI_DATA_WIDTH = 128,
  parameter int unsigned P_AXI_ADDR_WIDTH = 32,
  parameter int unsigned P_CH_W           = $clog2(P_CH_NUM)
) (
  input  logic                                 i_user_clk,
  input  logic                                 i_rst,
  input  logic                                 i_ddr_init,
  input  logic [P_CH_NUM-1:0]                  i_user_req,
  input  logic [P_CH_NUM*P_AXI_ADDR_WIDTH-1:0] i_user_baddr,
  input  logic [P_CH_NUM*P_AXI_ADDR_WIDTH-1:0] i_user_faddr,
  output logic [P_CH_NUM-1:0]                  o_user_busy,
  output logic                                 o_axi_u2a_rden,
  output logic [P_AXI_ADDR_WIDTH-1:0]          o_axi_u2a_addr,
  output logic [7:0]                           o_axi_u2a_length,
  output logic [P_CH_W-1:0]                    o_axi_u2a_ch,
  input  logic [P_CH_NUM-1:0]                  i_buffer_ready
);

  localparam int unsigned AW = P_AXI_ADDR_WIDTH;
  localparam int unsigned LP_BURST_LEN = burst_len(P_WR_LENGTH, P_AXI_DATA_WIDTH);
  localparam logic [AW:0] LP_STEP = (AW + 1)'(P_WR_LENGTH);

  state_e              r_state, w_state_nxt;
  logic                r_init_meta, r_init_sync;
  logic                w_ddr_ok;
  logic [P_CH_NUM-1:0] w_pend;
  logic [P_CH_NUM-1:0] w_addr_vld;
  logic [AW-1:0]       w_cur_addr [P_CH_NUM];
  logic [AW-1:0]       w_baddr    [P_CH_NUM];
  logic [AW-1:0]       w_faddr    [P_CH_NUM];
  logic [P_CH_W-1:0]   r_sel, r_last_grant, w_grant;
  logic                w_grant_vld;
  logic                r_rden;
  logic [AW-1:0]       r_addr;
  logic                w_hs;
  logic [AW:0]         w_sum;
  logic [AW-1:0]       w_addr_next;

  assign w_ddr_ok         = r_init_sync;
  assign w_hs             = (r_state == StReq) & r_rden & i_buffer_ready[r_sel];
  assign o_axi_u2a_rden   = r_rden;
  assign o_axi_u2a_addr   = r_addr;
  assign o_axi_u2a_ch     = r_sel;
  assign o_axi_u2a_length = 8'(LP_BURST_LEN - 1);

  // One extra bit so a region ending at the top of the address space still wraps.
  assign w_sum       = {1'b0, r_addr} + LP_STEP;
  assign w_addr_next = (w_sum >= {1'b0, w_faddr[r_sel]}) ? w_baddr[r_sel] : w_sum[AW-1:0];

  // Two-flop synchroniser for DDR calibration done.
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      r_init_meta <= 1'b0;
      r_init_sync <= 1'b0;
    end else begin
      r_init_meta <= i_ddr_init;
      r_init_sync <= r_init_meta;
    end
  end

  for (genvar c = 0; c < P_CH_NUM; c++) begin : g_ch
    logic          r_req_meta, r_req_sync, r_req_s1, r_req_s2;
    logic          r_pend, r_addr_vld;
    logic [AW-1:0] r_cur_addr;
    logic          w_edge, w_mine;

    assign w_baddr[c]     = i_user_baddr[c*AW +: AW];
    assign w_faddr[c]     = i_user_faddr[c*AW +: AW];
    assign w_mine         = (r_sel == P_CH_W'(c));
    assign w_edge         = r_req_s1 & ~r_req_s2;
    assign o_user_busy[c] = r_pend | ((r_state != StIdle) & w_mine);
    assign w_pend[c]      = r_pend;
    assign w_addr_vld[c]  = r_addr_vld;
    assign w_cur_addr[c]  = r_cur_addr;

    // Synchronise the request, then detect its rising edge one stage later.
    always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
        r_req_meta <= 1'b0;
        r_req_sync <= 1'b0;
        r_req_s1   <= 1'b0;
        r_req_s2   <= 1'b0;
      end else begin
        r_req_meta <= i_user_req[c];
        r_req_sync <= r_req_meta;
        r_req_s1   <= r_req_sync;
        r_req_s2   <= r_req_s1;
      end
    end

    // Latch accepted edges; on this channel's handshake clear pend and advance the pointer.
    always_ff @(posedge i_user_clk or posedge i_rst) begin
      if (i_rst) begin
        r_pend     <= 1'b0;
        r_addr_vld <= 1'b0;
        r_cur_addr <= '0;
      end else if (w_hs && w_mine) begin
        r_pend     <= 1'b0;
        r_addr_vld <= 1'b1;
        r_cur_addr <= w_addr_next;
      end else if (w_edge && w_ddr_ok && !o_user_busy[c]) begin
        r_pend <= 1'b1;
      end
    end
  end

  rr_arbiter #(
    .P_CH_NUM(P_CH_NUM),
    .P_CH_W  (P_CH_W)
  ) u_arb (
    .i_req       (w_pend),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_valid     (w_grant_vld)
  );

  // FSM state register.
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (|w_pend) w_state_nxt = StArb;
      StArb:   w_state_nxt = w_grant_vld ? StReq : StIdle;
      StReq:   if (w_hs) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Command registers: loaded at arbitration, held through REQ, rden cleared on handshake.
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rden       <= 1'b0;
      r_addr       <= '0;
      r_sel        <= '0;
      r_last_grant <= P_CH_W'(P_CH_NUM - 1);
    end else if (r_state == StArb && w_grant_vld) begin
      r_sel        <= w_grant;
      r_last_grant <= w_grant;
      r_addr       <= w_addr_vld[w_grant] ? w_cur_addr[w_grant] : w_baddr[w_grant];
      r_rden       <= 1'b1;
    end else if (w_hs) begin
      r_rden <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rd_ctrl_mc.sv
// Scoreboard bench for rd_ctrl_mc: expected commands are queued as requests are driven
// and checked when the DUT handshakes a command.
module tb_rd_ctrl_mc;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam logic [31:0] STEP = 32'h1000;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            ddr_init;
  logic [N-1:0]    req, ready, busy;
  logic [N*AW-1:0] baddr, faddr;
  logic            rden;
  logic [AW-1:0]   addr;
  logic [7:0]      len;
  logic [1:0]      ch;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  logic [31:0] m_cur [N];

  always #5 clk = ~clk;

  rd_ctrl_mc #(
    .P_CH_NUM        (N),
    .P_WR_LENGTH     (4096),
    .P_AXI_DATA_WIDTH(128),
    .P_AXI_ADDR_WIDTH(AW)
  ) dut (
    .i_user_clk      (clk),
    .i_rst           (rst),
    .i_ddr_init      (ddr_init),
    .i_user_req      (req),
    .i_user_baddr    (baddr),
    .i_user_faddr    (faddr),
    .o_user_busy     (busy),
    .o_axi_u2a_rden  (rden),
    .o_axi_u2a_addr  (addr),
    .o_axi_u2a_length(len),
    .o_axi_u2a_ch    (ch),
    .i_buffer_ready  (ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int c);
    return 32'(c) * 32'h0010_0000;
  endfunction

  function automatic logic [31:0] end_of(input int c);
    return base_of(c) + 32'h0001_0000;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_cur[c] = base_of(c);
    q.delete();
  endtask

  // Queue the next command of channel c and advance the region model.
  task automatic push_exp(input int c);
    exp_t        e;
    logic [32:0] nxt;
    e.ch   = 2'(c);
    e.addr = m_cur[c];
    q.push_back(e);
    nxt = {1'b0, m_cur[c]} + {1'b0, STEP};
    if (nxt >= {1'b0, end_of(c)}) m_cur[c] = base_of(c);
    else                          m_cur[c] = nxt[31:0];
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    @(posedge clk);
    #1 req = req | mask;
    repeat (2) @(posedge clk);
    #1 req = req & ~mask;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && busy == '0 && !rden) break;
    end
    chk("idle_reached", k < 400, 1);
  endtask

  task automatic wait_rden();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (rden) break;
    end
    chk("rden_seen", rden, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
  endtask

  // Sample just before the handshake edge and check against the queue head.
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (!rst && rden && ready[ch]) begin
      hs_cnt++;
      chk("cmd_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("cmd_ch", ch, e.ch);
        chk("cmd_addr", addr, e.addr);
        chk("cmd_len", len, 8'd255);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        held;
    logic        seen;
    logic [31:0] a0;
    int          h0;
    rst      = 1'b1;
    ddr_init = 1'b0;
    req      = '0;
    ready    = '1;
    for (int c = 0; c < N; c++) begin
      baddr[c*AW +: AW] = base_of(c);
      faddr[c*AW +: AW] = end_of(c);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", rden, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ch", ch, 0);
    rst      = 1'b0;
    ddr_init = 1'b1;
    repeat (4) @(posedge clk);

    // Single command: exact latency and one-cycle rden with ready high.
    push_exp(0);
    @(posedge clk);
    #1 req[0] = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 chk("lat_edge4_low", rden, 0);
    @(posedge clk);
    #1 chk("lat_edge5_high", rden, 1);
    chk("busy_ch0", busy[0], 1);
    @(posedge clk);
    #1 chk("rden_one_cycle", rden, 0);
    req[0] = 1'b0;
    wait_idle();

    // Sixteen more on ch0: walks 0x1000..0xF000 then wraps to 0.
    for (int i = 1; i <= 16; i++) begin
      push_exp(0);
      pulse(4'b0001);
      wait_idle();
    end

    // Round-robin from reset, then ch3+ch0 after last grant 3.
    do_reset();
    for (int c = 0; c < N; c++) push_exp(c);
    pulse(4'b1111);
    wait_idle();
    push_exp(0);
    push_exp(3);
    pulse(4'b1001);
    wait_idle();

    // Back-pressure on ch1: command held stable; other channels' ready ignored.
    ready[1] = 1'b0;
    push_exp(1);
    h0 = hs_cnt;
    pulse(4'b0010);
    wait_rden();
    a0   = addr;
    held = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!rden || addr !== a0 || ch !== 2'd1 || !busy[1]) held = 1'b0;
    end
    chk("hold_stable", held, 1);
    chk("hold_no_hs", hs_cnt - h0, 0);
    ready[1] = 1'b1;
    wait_idle();

    // DDR not ready: edges dropped.
    ddr_init = 1'b0;
    repeat (4) @(posedge clk);
    pulse(4'b0100);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rden || busy != '0) seen = 1'b1;
    end
    chk("noinit_no_cmd", seen, 0);
    ddr_init = 1'b1;
    repeat (4) @(posedge clk);

    // Second edge while busy is dropped: exactly one command.
    h0       = hs_cnt;
    ready[2] = 1'b0;
    push_exp(2);
    pulse(4'b0100);
    wait_rden();
    pulse(4'b0100);
    repeat (10) @(posedge clk);
    #1 ready[2] = 1'b1;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    chk("busy_edge_one_cmd", hs_cnt - h0, 1);
    chk("busy_edge_idle", busy, 0);

    // Reset during REQ: rden drops at once, region restarts at base.
    ready[0] = 1'b0;
    push_exp(0);
    pulse(4'b0001);
    wait_rden();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_rden", rden, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    ready = '1;
    repeat (4) @(posedge clk);
    push_exp(0);
    pulse(4'b0001);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
